avaliador_niveis: RTL

//  Registered level-evaluation FSM: keeps a current level, scores each N-bit test word by popcount,

---
 rtl/avaliacao_pkg.sv | 21 ++
 rtl/avaliador_niveis_if.sv | 26 ++
 rtl/decod_7seg.sv | 9 +
 rtl/avaliador_niveis.sv | 133 +++++++++++++
 4 files changed

// File: rtl/avaliacao_pkg.sv
// rtl/avaliacao_pkg.sv - shared FSM states, popcount helper and hex glyph table
package avaliacao_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DECIDE} state_t;

    // Segment order a..g, a in the MSB, active high
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [5:0] popcount(input logic [31:0] v);
        popcount = '0;
        for (int i = 0; i < 32; i++) begin
            popcount = popcount + 6'(v[i]);
        end
    endfunction

endpackage

// File: rtl/avaliador_niveis_if.sv
// rtl/avaliador_niveis_if.sv - test-word handshake, load and level display bundle
interface avaliador_niveis_if #(
    parameter int N_BITS = 4,
    parameter int LW     = 2
);
    logic [N_BITS-1:0] p;
    logic              p_valid;
    logic              p_ready;
    logic              carga;
    logic [LW-1:0]     nivel_init;
    logic [LW-1:0]     nivel;
    logic              nivel_valid;
    logic              seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    modport slave (
        input  p, p_valid, carga, nivel_init,
        output p_ready, nivel, nivel_valid,
        output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
    );

    modport master (
        output p, p_valid, carga, nivel_init,
        input  p_ready, nivel, nivel_valid,
        input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
    );
endinterface

// File: rtl/decod_7seg.sv
// rtl/decod_7seg.sv - combinational hex digit to a..g segment decoder
module decod_7seg
    import avaliacao_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[digit];
endmodule

// File: rtl/avaliador_niveis.sv
// rtl/avaliador_niveis.sv - popcount level evaluator with registered hex display
// Optional AVALIADOR_ESTATISTICA_EN adds saturating promotion/demotion counters.
module avaliador_niveis
    import avaliacao_pkg::*;
#(
    parameter int N_BITS         = 4,
    parameter int NUM_NIVEIS     = 4,
    parameter int LIMIAR_PROMO   = 3,
    parameter int LIMIAR_REBAIXA = 1,
    parameter int CONSEC         = 2
) (
    input  logic clk,
    input  logic rst_n,
    avaliador_niveis_if.slave bus
`ifdef AVALIADOR_ESTATISTICA_EN
    ,
    output logic [7:0] n_promo,
    output logic [7:0] n_rebaixa
`endif
);
    localparam int LW = (NUM_NIVEIS <= 2) ? 1 : $clog2(NUM_NIVEIS);
    localparam int SW = $clog2(N_BITS + 1);
    localparam int CW = (CONSEC <= 2) ? 1 : $clog2(CONSEC);
    localparam logic [LW-1:0] NIVEL_MAX = LW'(NUM_NIVEIS - 1);
    localparam logic [SW-1:0] S_PROMO   = SW'(LIMIAR_PROMO);
    localparam logic [SW-1:0] S_REBAIXA = SW'(LIMIAR_REBAIXA);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CONSEC - 1);

    state_t            state, state_next;
    logic [N_BITS-1:0] p_reg;
    logic [SW-1:0]     score;
    logic [LW-1:0]     nivel_q, nivel_next;
    logic [CW-1:0]     promo_cnt, promo_next;
    logic [6:0]        seg_q, seg_dec;
    logic              valid_q, upd, do_promo, do_rebaixa, load, transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = CALC;
            CALC:    state_next = DECIDE;
            DECIDE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The load strobe pre-empts the handshake, so p_ready drops with carga.
    always_comb begin
        bus.p_ready = (state == IDLE) && !bus.carga;
        load        = (state == IDLE) && bus.carga;
        transfer    = (state == IDLE) && !bus.carga && bus.p_valid;
    end

    always_comb begin
        nivel_next = nivel_q;
        promo_next = promo_cnt;
        upd        = 1'b0;
        do_promo   = 1'b0;
        do_rebaixa = 1'b0;
        if (load) begin
            nivel_next = (bus.nivel_init > NIVEL_MAX) ? NIVEL_MAX : bus.nivel_init;
            promo_next = '0;
            upd        = 1'b1;
        end else if (state == DECIDE) begin
            upd = 1'b1;
            if (score <= S_REBAIXA) begin
                promo_next = '0;
                if (nivel_q != '0) begin
                    nivel_next = nivel_q - 1'b1;
                    do_rebaixa = 1'b1;
                end
            end else if (score >= S_PROMO) begin
                if (promo_cnt == CNT_LAST) begin
                    promo_next = '0;
                    if (nivel_q != NIVEL_MAX) begin
                        nivel_next = nivel_q + 1'b1;
                        do_promo   = 1'b1;
                    end
                end else begin
                    promo_next = promo_cnt + 1'b1;
                end
            end else begin
                promo_next = '0;
            end
        end
    end

    decod_7seg u_decod (
        .digit(4'(nivel_next)),
        .seg  (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg     <= '0;
            score     <= '0;
            nivel_q   <= '0;
            promo_cnt <= '0;
            valid_q   <= 1'b0;
            seg_q     <= SEG_HEX[0];
        end else begin
            if (transfer) p_reg <= bus.p;
            if (state == CALC) score <= SW'(popcount(32'(p_reg)));
            nivel_q   <= nivel_next;
            promo_cnt <= promo_next;
            valid_q   <= upd;
            seg_q     <= seg_dec;
        end
    end

`ifdef AVALIADOR_ESTATISTICA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_promo   <= '0;
            n_rebaixa <= '0;
        end else begin
            if (do_promo && n_promo != 8'hFF)     n_promo   <= n_promo + 8'd1;
            if (do_rebaixa && n_rebaixa != 8'hFF) n_rebaixa <= n_rebaixa + 8'd1;
        end
    end
`endif

    assign bus.nivel       = nivel_q;
    assign bus.nivel_valid = valid_q;
    assign {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
            bus.seg_e, bus.seg_f, bus.seg_g} = seg_q;

endmodule
